hilo_muldiv: RTL and testbench

Execute-stage multiply/divide unit and HI/LO register pair for the MIPS pipeline. It is the consumer end of the main decoder's 6-bit `aluop` command field: it executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It holds the pipeline with `stall_o` while a multi-cycle operation runs. All other aluop codes are ignored here and go to the ALU.

---
 rtl/hilo_muldiv.sv | 172 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit with the HI/LO register pair.
// Mult takes one extra cycle, div is a 32-step restoring divider; the pipeline is held via stall_o.
module hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validE,
  input  logic [5:0]       aluopE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mfresult_o,
  output logic             stall_o
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] OP_MULT  = 6'b011011;
  localparam logic [5:0] OP_MULTU = 6'b001011;
  localparam logic [5:0] OP_DIV   = 6'b011100;
  localparam logic [5:0] OP_DIVU  = 6'b001100;
  localparam logic [5:0] OP_MTHI  = 6'b100000;
  localparam logic [5:0] OP_MTLO  = 6'b100001;
  localparam logic [5:0] OP_MFHI  = 6'b100010;
  localparam logic [5:0] OP_MFLO  = 6'b100011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;      // multiplicand, or dividend magnitude shifting into quotient
  logic [WIDTH-1:0] b_q, b_d;      // multiplier, or divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_mul, is_div, is_signed, start;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [DW-1:0]    a_ext, b_ext, prod;
  logic [WIDTH:0]   rem_sh, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx, quo_nx, quo_fin, rem_fin;

  // Command decode and start qualification
  always_comb begin
    is_mul    = (aluopE == OP_MULT) || (aluopE == OP_MULTU);
    is_div    = (aluopE == OP_DIV)  || (aluopE == OP_DIVU);
    is_signed = (aluopE == OP_MULT) || (aluopE == OP_DIV);
    start     = (state_q == IDLE) && validE && !flushE && (is_mul || is_div);
    abs_a     = (is_signed && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    abs_b     = (is_signed && srcbE[WIDTH-1]) ? -srcbE : srcbE;
  end

  // Datapath: full-width product and one restoring-divide step
  always_comb begin
    a_ext   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = a_ext * b_ext;
    rem_sh  = {rem_q, a_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_q};
    q_bit   = !diff[WIDTH];
    rem_nx  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx  = {a_q[WIDTH-2:0], q_bit};
    quo_fin = negq_q ? -quo_nx : quo_nx;
    rem_fin = negr_q ? -rem_nx : rem_nx;
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flushE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && is_mul) begin
            a_d     = srcaE;
            b_d     = srcbE;
            sgn_d   = is_signed;
            state_d = MUL;
          end else if (start && is_div) begin
            a_d     = abs_a;
            b_d     = abs_b;
            rem_d   = '0;
            cnt_d   = '0;
            sgn_d   = is_signed;
            negq_d  = is_signed && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            negr_d  = is_signed && srcaE[WIDTH-1];
            state_d = (srcbE == '0) ? DONE : DIV;
          end else if (validE && aluopE == OP_MTHI) begin
            hi_d = srcaE;
          end else if (validE && aluopE == OP_MTLO) begin
            lo_d = srcaE;
          end
        end
        MUL: begin
          hi_d    = prod[DW-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          state_d = DONE;
        end
        DIV: begin
          a_d   = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            lo_d    = quo_fin;
            hi_d    = rem_fin;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Hold request is suppressed while reset is asserted
  always_comb begin
    stall_o = rst && !flushE && (start || state_q == MUL || state_q == DIV);
    case (aluopE)
      OP_MFHI: mfresult_o = hi_q;
      OP_MFLO: mfresult_o = lo_q;
      default: mfresult_o = '0;
    endcase
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed and random ops against an arithmetic reference model.
module tb_hilo_muldiv;

  localparam logic [5:0] OP_MULT  = 6'b011011;
  localparam logic [5:0] OP_MULTU = 6'b001011;
  localparam logic [5:0] OP_DIV   = 6'b011100;
  localparam logic [5:0] OP_DIVU  = 6'b001100;
  localparam logic [5:0] OP_MTHI  = 6'b100000;
  localparam logic [5:0] OP_MTLO  = 6'b100001;
  localparam logic [5:0] OP_MFHI  = 6'b100010;
  localparam logic [5:0] OP_MFLO  = 6'b100011;

  logic        clk;
  logic        rst;
  logic        validE;
  logic [5:0]  aluopE;
  logic        flushE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] mfresult_o;
  logic        stall_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .validE(validE), .aluopE(aluopE), .flushE(flushE),
    .srcaE(srcaE), .srcbE(srcbE), .hi_o(hi_o), .lo_o(lo_o),
    .mfresult_o(mfresult_o), .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: HI/LO after an op and the number of stalled cycles
  task automatic model_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int st);
    longint          sp, sq, sr;
    longint unsigned up, uq, ur;
    st = 0;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0]; st = 2;
      end
      OP_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        m_hi = up[63:32]; m_lo = up[31:0]; st = 2;
      end
      OP_DIV: begin
        st = 1;
        if (b != 0) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          m_lo = sq[31:0]; m_hi = sr[31:0]; st = 33;
        end
      end
      OP_DIVU: begin
        st = 1;
        if (b != 0) begin
          uq = {32'h0, a} / {32'h0, b};
          ur = {32'h0, a} % {32'h0, b};
          m_lo = uq[31:0]; m_hi = ur[31:0]; st = 33;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one instruction, hold it while stalled, release after the edge that retires it
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stall_cycles);
    @(negedge clk);
    validE = 1'b1; aluopE = op; srcaE = a; srcbE = b;
    stall_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall_o) break;
      stall_cycles++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    validE = 1'b0; aluopE = 6'h0; srcaE = 32'h0; srcbE = 32'h0;
  endtask

  task automatic check_op(input string name, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    int st_exp, st_got;
    model_op(op, a, b, st_exp);
    run_op(op, a, b, st_got);
    checks++;
    if (st_got != st_exp) begin
      errors++;
      $display("FAIL %s stall a=%h b=%h got=%0d exp=%0d", name, a, b, st_got, st_exp);
    end
    checks++;
    if (hi_o !== m_hi || lo_o !== m_lo) begin
      errors++;
      $display("FAIL %s hilo a=%h b=%h got=%h/%h exp=%h/%h", name, a, b, hi_o, lo_o, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; validE = 1'b1; aluopE = OP_DIV; flushE = 1'b0; srcaE = 32'd5; srcbE = 32'd1;
    #1 rst = 1'b0;
    #2;
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset got hi=%h lo=%h stall=%b exp 0/0/0", hi_o, lo_o, stall_o);
    end
    aluopE = OP_MFHI;
    #1;
    checks++;
    if (mfresult_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mfhi got=%h exp=0", mfresult_o);
    end
    validE = 1'b0; aluopE = 6'h0; srcaE = 32'h0; srcbE = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
  endtask

  task automatic test_mul();
    logic [31:0] a, b;
    check_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5);
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      check_op("mul_rand", (i % 2 == 0) ? OP_MULT : OP_MULTU, a, b);
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    check_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2);
    check_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE);
    check_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 2 == 1) b = -b;
      if (b == 32'h0) b = 32'd3;
      check_op("div_rand", (i % 3 == 0) ? OP_DIVU : OP_DIV, a, b);
    end
  endtask

  task automatic test_div_zero();
    check_op("mthi_11", OP_MTHI, 32'h11, 32'h0);
    check_op("mtlo_22", OP_MTLO, 32'h22, 32'h0);
    check_op("div_by_zero", OP_DIV, 32'd1234, 32'h0);
    check_op("divu_by_zero", OP_DIVU, 32'hFFFF0000, 32'h0);
    check_op("b2b_after_dz", OP_MULT, 32'd7, 32'hFFFFFFFF);
  endtask

  task automatic test_flush();
    logic [31:0] h0, l0;
    h0 = hi_o; l0 = lo_o;
    @(negedge clk);
    validE = 1'b1; aluopE = OP_DIVU; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_stall got=%b exp=1", stall_o);
    end
    flushE = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall_drop got=%b exp=0", stall_o);
    end
    @(posedge clk);
    #1;
    flushE = 1'b0; validE = 1'b0; aluopE = 6'h0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || hi_o !== h0 || lo_o !== l0) begin
      errors++;
      $display("FAIL flush_abort got stall=%b hilo=%h/%h exp 0 %h/%h", stall_o, hi_o, lo_o, h0, l0);
    end
    check_op("divu_after_flush", OP_DIVU, 32'd9, 32'd3);
    @(negedge clk);
    validE = 1'b1; aluopE = OP_MULT; srcaE = 32'd4; srcbE = 32'd4; flushE = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall got=%b exp=0", stall_o);
    end
    @(posedge clk);
    #1;
    validE = 1'b0; flushE = 1'b0; aluopE = 6'h0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || hi_o !== m_hi || lo_o !== m_lo) begin
      errors++;
      $display("FAIL flush_start_nochange got stall=%b hilo=%h/%h exp 0 %h/%h",
               stall_o, hi_o, lo_o, m_hi, m_lo);
    end
  endtask

  task automatic test_mtmf();
    logic [31:0] d;
    check_op("mthi", OP_MTHI, 32'h12345678, 32'h0);
    check_op("mtlo", OP_MTLO, 32'h9ABCDEF0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      check_op("mt_rand", (i % 2 == 0) ? OP_MTHI : OP_MTLO, d, 32'h0);
    end
    check_op("mthi", OP_MTHI, 32'h12345678, 32'h0);
    check_op("mtlo", OP_MTLO, 32'h9ABCDEF0, 32'h0);
    @(negedge clk);
    validE = 1'b1; aluopE = OP_MFHI;
    #1;
    checks++;
    if (mfresult_o !== 32'h12345678 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL mfhi got=%h stall=%b exp=12345678 0", mfresult_o, stall_o);
    end
    aluopE = OP_MFLO;
    #1;
    checks++;
    if (mfresult_o !== 32'h9ABCDEF0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL mflo got=%h stall=%b exp=9abcdef0 0", mfresult_o, stall_o);
    end
    aluopE = 6'b000001;
    #1;
    checks++;
    if (mfresult_o !== 32'h0) begin
      errors++;
      $display("FAIL mf_other got=%h exp=0", mfresult_o);
    end
    validE = 1'b0; aluopE = OP_DIV;
    #1;
    checks++;
    if (mfresult_o !== 32'h0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL novalid got=%h stall=%b exp=0 0", mfresult_o, stall_o);
    end
    aluopE = 6'h0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    validE = 1'b1; aluopE = OP_DIVU; srcaE = 32'hDEADBEEF; srcbE = 32'd17;
    repeat (21) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop got hi=%h lo=%h stall=%b exp 0/0/0", hi_o, lo_o, stall_o);
    end
    validE = 1'b0; aluopE = 6'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    check_op("mult_after_rst", OP_MULT, 32'd2, 32'd3);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_mult", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_op("b2b_div", OP_DIV, 32'hFFFFFF00, 32'd7);
    check_op("b2b_multu", OP_MULTU, 32'h00010000, 32'h00010000);
    check_op("b2b_divu", OP_DIVU, 32'hFFFFFFFF, 32'd1);
  endtask

  initial begin
    rst = 1'b1; validE = 1'b0; aluopE = 6'h0; flushE = 1'b0; srcaE = 32'h0; srcbE = 32'h0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_mtmf();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
